// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin share of one MemoryBus slave among PORTS requesters,
// requester index carried in the top ID bits and used to route read responses back.
module memory_arbiter #(
  parameter int PORTS = 4,
  parameter int IDW = 6,
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int PB = $clog2(PORTS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PORTS-1:0]          rq_msValid,
  input  logic [PORTS-1:0]          rq_msWrite,
  input  logic [PORTS-1:0][AW-1:0]  rq_msAddress,
  input  logic [PORTS-1:0][DW-1:0]  rq_msData,
  input  logic [PORTS-1:0][IDW-1:0] rq_msID,
  output logic [PORTS-1:0]          rq_msTaken,
  output logic [PORTS-1:0]          rq_smValid,
  output logic [PORTS-1:0][DW-1:0]  rq_smData,
  output logic [PORTS-1:0][IDW-1:0] rq_smID,
  input  logic [PORTS-1:0]          rq_smTaken,
  output logic                      dn_msValid,
  output logic                      dn_msWrite,
  output logic [AW-1:0]             dn_msAddress,
  output logic [DW-1:0]             dn_msData,
  output logic [IDW-1:0]            dn_msID,
  input  logic                      dn_msTaken,
  input  logic                      dn_smValid,
  input  logic [DW-1:0]             dn_smData,
  input  logic [IDW-1:0]            dn_smID,
  output logic                      dn_smTaken
);
  logic [PB-1:0] last, winner, idx, p;
  logic found, slot_free, grant, unused_id;
  assign unused_id = ^rq_msID;
  assign slot_free = !dn_msValid || dn_msTaken;
  // scan last+1 .. last+PORTS; PB-bit wraparound gives the modulo for free
  always_comb begin
    found = 1'b0;
    winner = last;
    idx = last;
    for (int i = 1; i <= PORTS; i++) begin
      idx = last + PB'(i);
      if (!found && rq_msValid[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  assign grant = slot_free && found;
  assign rq_msTaken = grant ? PORTS'(1) << winner : '0;
  assign p = dn_smID[IDW-1 -: PB];
  assign dn_smTaken = !rq_smValid[p] || rq_smTaken[p];
  always_ff @(posedge clock) begin
    if (reset) begin
      dn_msValid <= 1'b0;
      last <= PB'(PORTS-1);
    end else if (slot_free) begin
      dn_msValid <= found;
      if (found) begin
        last <= winner;
        dn_msWrite <= rq_msWrite[winner];
        dn_msAddress <= rq_msAddress[winner];
        dn_msData <= rq_msData[winner];
        dn_msID <= {winner, rq_msID[winner][IDW-PB-1:0]};
      end
    end
  end
  // a refill of a port takes precedence over its requester draining it
  always_ff @(posedge clock) begin
    for (int i = 0; i < PORTS; i++) begin
      if (reset) rq_smValid[i] <= 1'b0;
      else if (dn_smValid && dn_smTaken && p == PB'(i)) begin
        rq_smValid[i] <= 1'b1;
        rq_smData[i] <= dn_smData;
        rq_smID[i] <= {{PB{1'b0}}, dn_smID[IDW-PB-1:0]};
      end else if (rq_smTaken[i]) rq_smValid[i] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_memory_arbiter;
  localparam int P = 4, IDW = 6, AW = 32, DW = 32, PB = 2;
  logic clock = 1'b0, reset;
  logic [P-1:0] rq_msValid, rq_msWrite, rq_msTaken, rq_smValid, rq_smTaken;
  logic [P-1:0][AW-1:0] rq_msAddress;
  logic [P-1:0][DW-1:0] rq_msData, rq_smData;
  logic [P-1:0][IDW-1:0] rq_msID, rq_smID;
  logic dn_msValid, dn_msWrite, dn_msTaken, dn_smValid, dn_smTaken;
  logic [AW-1:0] dn_msAddress;
  logic [DW-1:0] dn_msData, dn_smData;
  logic [IDW-1:0] dn_msID, dn_smID;
  int total = 0, bad = 0;
  bit m_dv, m_dw;
  logic [AW-1:0] m_da;
  logic [DW-1:0] m_dd;
  logic [IDW-1:0] m_did;
  int m_last;
  bit m_sv[P];
  logic [DW-1:0] m_sd[P];
  logic [IDW-1:0] m_sid[P];
  int order[6] = '{0, 1, 2, 3, 0, 1};

  always #5 clock = ~clock;

  memory_arbiter #(.PORTS(P), .IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .rq_msValid(rq_msValid), .rq_msWrite(rq_msWrite), .rq_msAddress(rq_msAddress),
    .rq_msData(rq_msData), .rq_msID(rq_msID), .rq_msTaken(rq_msTaken),
    .rq_smValid(rq_smValid), .rq_smData(rq_smData), .rq_smID(rq_smID), .rq_smTaken(rq_smTaken),
    .dn_msValid(dn_msValid), .dn_msWrite(dn_msWrite), .dn_msAddress(dn_msAddress),
    .dn_msData(dn_msData), .dn_msID(dn_msID), .dn_msTaken(dn_msTaken),
    .dn_smValid(dn_smValid), .dn_smData(dn_smData), .dn_smID(dn_smID), .dn_smTaken(dn_smTaken)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dv = 0;
    m_last = P - 1;
    for (int i = 0; i < P; i++) m_sv[i] = 0;
  endtask

  task automatic idle();
    rq_msValid = '0; rq_msWrite = '0; rq_msAddress = '0; rq_msData = '0; rq_msID = '0;
    rq_smTaken = '0; dn_msTaken = 0; dn_smValid = 0; dn_smData = '0; dn_smID = '0;
  endtask

  // compare every output against the model, advance the model, cross the clock edge
  task automatic step();
    int win, q, pp;
    bit sf, st;
    logic [P-1:0] et;
    win = -1;
    sf = !m_dv || dn_msTaken;
    for (int k = 1; k <= P; k++) begin
      q = (m_last + k) % P;
      if (win < 0 && rq_msValid[q]) win = q;
    end
    et = (sf && win >= 0) ? P'(1) << win : '0;
    pp = int'(dn_smID) / (1 << (IDW - PB));
    st = !m_sv[pp] || rq_smTaken[pp];
    chk("rq_msTaken", rq_msTaken, et);
    chk("dn_msValid", dn_msValid, m_dv);
    if (m_dv) begin
      chk("dn_msWrite", dn_msWrite, m_dw);
      chk("dn_msAddress", dn_msAddress, m_da);
      chk("dn_msData", dn_msData, m_dd);
      chk("dn_msID", dn_msID, m_did);
    end
    chk("dn_smTaken", dn_smTaken, st);
    for (int i = 0; i < P; i++) begin
      chk("rq_smValid", rq_smValid[i], m_sv[i]);
      if (m_sv[i]) begin
        chk("rq_smData", rq_smData[i], m_sd[i]);
        chk("rq_smID", rq_smID[i], m_sid[i]);
      end
    end
    if (reset) model_reset();
    else begin
      if (sf) begin
        m_dv = win >= 0;
        if (win >= 0) begin
          m_dw = rq_msWrite[win];
          m_da = rq_msAddress[win];
          m_dd = rq_msData[win];
          m_did = IDW'(win * (1 << (IDW - PB)) + int'(rq_msID[win]) % (1 << (IDW - PB)));
          m_last = win;
        end
      end
      for (int i = 0; i < P; i++) begin
        if (dn_smValid && st && i == pp) begin
          m_sv[i] = 1;
          m_sd[i] = dn_smData;
          m_sid[i] = IDW'(int'(dn_smID) % (1 << (IDW - PB)));
        end else if (rq_smTaken[i]) m_sv[i] = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #1;
    step();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clock);
    #1;
    model_reset();
    #1;
    chk("reset dn_msValid", dn_msValid, 1'b0);
    chk("reset rq_smValid", rq_smValid, 4'b0000);
    chk("reset dn_smTaken", dn_smTaken, 1'b1);
    step();
    reset = 0;
    // single port read on port 2
    idle();
    rq_msValid = 4'b0100; rq_msAddress[2] = 32'h100; rq_msID[2] = 6'h3; dn_msTaken = 1;
    #1;
    chk("t1 grant", rq_msTaken, 4'b0100);
    step();
    idle();
    dn_msTaken = 1; dn_smValid = 1; dn_smID = 6'h23; dn_smData = 32'hDEADBEEF;
    #1;
    chk("t1 dn_msValid", dn_msValid, 1'b1);
    chk("t1 dn_msID", dn_msID, 6'h23);
    chk("t1 dn_msAddress", dn_msAddress, 32'h100);
    chk("t1 dn_smTaken", dn_smTaken, 1'b1);
    step();
    idle();
    rq_smTaken = 4'b0100;
    #1;
    chk("t1 rq_smValid", rq_smValid, 4'b0100);
    chk("t1 rq_smData", rq_smData[2], 32'hDEADBEEF);
    chk("t1 rq_smID", rq_smID[2], 6'h03);
    step();
    // round-robin from reset
    do_reset();
    rq_msValid = 4'b1111; dn_msTaken = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr grant", rq_msTaken, 4'(1) << order[c]);
      if (c >= 1) chk("rr dn_msValid", dn_msValid, 1'b1);
      step();
    end
    // back-pressure
    do_reset();
    rq_msValid = 4'b1010; rq_msAddress[1] = 32'h1111; rq_msAddress[3] = 32'h3333; dn_msTaken = 1;
    #1;
    chk("bp first grant", rq_msTaken, 4'b0010);
    step();
    dn_msTaken = 0;
    repeat (5) begin
      #1;
      chk("bp rq_msTaken", rq_msTaken, 4'b0000);
      chk("bp dn_msAddress", dn_msAddress, 32'h1111);
      chk("bp dn_msID", dn_msID, 6'h10);
      step();
    end
    dn_msTaken = 1;
    #1;
    chk("bp release grant", rq_msTaken, 4'b1000);
    step();
    #1;
    chk("bp next addr", dn_msAddress, 32'h3333);
    chk("bp next id", dn_msID, 6'h30);
    // response blocking, then same-cycle take and refill
    do_reset();
    dn_smValid = 1; dn_smID = 6'h05; dn_smData = 32'hA;
    #1;
    step();
    dn_smData = 32'hB;
    repeat (3) begin
      #1;
      chk("blk dn_smTaken", dn_smTaken, 1'b0);
      step();
    end
    rq_smTaken = 4'b0001;
    #1;
    chk("blk released", dn_smTaken, 1'b1);
    step();
    rq_smTaken = 4'b0000; dn_smID = 6'h17; dn_smData = 32'hC;
    #1;
    chk("blk port0 data", rq_smData[0], 32'hB);
    chk("blk valid", rq_smValid, 4'b0001);
    chk("blk port1 free", dn_smTaken, 1'b1);
    step();
    rq_smTaken = 4'b0010; dn_smID = 6'h18; dn_smData = 32'hD;
    #1;
    chk("refill before", rq_smData[1], 32'hC);
    chk("refill taken", dn_smTaken, 1'b1);
    step();
    idle();
    #1;
    chk("refill valid", rq_smValid, 4'b0011);
    chk("refill data", rq_smData[1], 32'hD);
    chk("refill id", rq_smID[1], 6'h08);
    step();
    // reset mid-transfer
    do_reset();
    rq_msValid = 4'b1000; dn_msTaken = 1; dn_smValid = 1; dn_smID = 6'h11;
    #1;
    step();
    idle();
    dn_smValid = 1; dn_smID = 6'h32;
    #1;
    step();
    idle();
    #1;
    chk("mid dn_msValid", dn_msValid, 1'b1);
    chk("mid rq_smValid", rq_smValid, 4'b1010);
    reset = 1;
    step();
    reset = 0;
    rq_msValid = 4'b1111; dn_msTaken = 1;
    #1;
    chk("post dn_msValid", dn_msValid, 1'b0);
    chk("post rq_smValid", rq_smValid, 4'b0000);
    chk("post grant", rq_msTaken, 4'b0001);
    step();
    // random traffic
    repeat (3000) begin
      reset = $urandom_range(0, 199) == 0;
      rq_msValid = P'($urandom);
      rq_msWrite = P'($urandom);
      for (int i = 0; i < P; i++) begin
        rq_msAddress[i] = $urandom;
        rq_msData[i] = $urandom;
        rq_msID[i] = IDW'($urandom);
      end
      rq_smTaken = P'($urandom);
      dn_msTaken = $urandom_range(0, 3) != 0;
      dn_smValid = $urandom_range(0, 1) == 1;
      dn_smData = $urandom;
      dn_smID = IDW'($urandom);
      #1;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
